bitmap_access_arbiter: RTL
==========================

# bitmap_access_arbiter

Owns the 1-bit display bitmap (ROWS × COLS, row-addressed) and shares it between the VGA scan-out path and two drawing clients. Scan-out row fetches always win. A bulk-clear sequencer comes next, then two masked row writers under round-robin arbitration. Writes and clears are confined to a software-selectable tearing-safe window, normally vertical blanking.

## Interface
- ROWS, 28, bitmap height in rows
- COLS, 80, bitmap width in pixels (bits per row word)
- ROW_W, 5, row address width, ≥ clog2(ROWS)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-low
- wr_window  in  1  high = writes/clear may be granted (driven from v_sync/blank logic)
- disp_req  in  1  scan-out row fetch request, single-cycle pulse
- disp_row  in  ROW_W  row to fetch
- disp_data  out  COLS  fetched row, bit 0 = leftmost pixel
- disp_valid  out  1  disp_data valid pulse
- w0_req / w1_req  in  1  writer request, level
- w0_row / w1_row  in  ROW_W  target row
- w0_data / w1_data  in  COLS  write data
- w0_mask / w1_mask  in  COLS  per-bit write enable
- w0_gnt / w1_gnt  out  1  write-committed pulse
- clr_req  in  1  start bulk clear, pulse
- clr_busy  out  1  clear in progress
- clr_done  out  1  clear-complete pulse

## Operation
- Arbitration priority per cycle: disp_req > clear step > writers.
- **Scan-out:** disp_req is serviced unconditionally, regardless of wr_window. The row is read in cycle t. If disp_row ≥ ROWS, disp_data = 0.
- **Clear FSM, IDLE → CLEAR:**
  - Entered on clr_req. The row counter loads 0.
  - In CLEAR, each cycle with wr_window=1 and disp_req=0 zeroes mem[counter] and increments the counter.
  - Writing row ROWS−1 returns the FSM to IDLE.
  - clr_req while in CLEAR restarts the counter at 0.
  - Writers are never granted while in CLEAR.
- **Writers:** eligible only when wr_window=1, disp_req=0, the FSM is in IDLE, and the requester's gnt is low this cycle.
  - Commit: mem[row] ← (mem[row] & ~mask) | (data & mask).
  - Both eligible: the writer not granted last wins. A single eligible writer always wins.
  - Tie pointer resets to "w1 last", so w0 wins the first tie.
  - Row ≥ ROWS: the request is granted but discarded, with no memory change.
- **Writer handshake:** hold req, row, data and mask stable until gnt. A writer may deassert req, or present a new request, in the gnt cycle; the new request is arbitrated from the following cycle.
- **Memory:** not reset. The simulation model initialises it to 0. Software clears after reset.

## Timing
- Reset values: disp_data=0, disp_valid=0, w0_gnt=w1_gnt=0, clr_busy=0, clr_done=0. On reset the FSM goes to IDLE, the counter to 0, and the tie pointer to w1.
- Scan-out latency: disp_req in cycle t → disp_data/disp_valid registered in t+1. disp_valid is high exactly one cycle.
- Write: arbitration in t, memory updated at the end of t, gnt high in t+1 only.
- Same-row write granted in t and disp_req for that row in t+1: the read returns the new data.
- A blocked writer keeps waiting; there is no timeout.
- Worst-case writer wait is one grant to the other writer plus any display/clear cycles.
- clr_busy: high from the cycle after clr_req until the cycle after the last row is cleared.
- clr_done: one-cycle pulse coincident with clr_busy falling.
- Minimum clear duration: ROWS cycles.
- Reset mid-clear: aborted immediately. Remaining rows keep their contents, and clr_done does not fire.
- wr_window falling mid-clear: the sequence pauses and resumes at the same row when the window reopens.

## Structure
- Shared package `bitmap_pkg`:
  - ROWS, COLS, ROW_W defaults
  - clear FSM state enum {ST_IDLE, ST_CLEAR}
- Sub-module `rr_arb2`: two-request round-robin arbiter with a one-hot grant and a registered last-grant pointer.
- Everything else (memory array, clear counter, output registers) lives in the top level.

## Test plan
- Reset, clr_req with wr_window=1 → clr_busy high for 28 cycles, clr_done pulse, and disp fetch of each row 0..27 returns 80'h0.
- w0 writes row 3, data all-ones, mask 80'h00000_0000F_FFFF_00000 → w0_gnt at t+1; fetch of row 3 returns exactly the masked bits set.
- w0 and w1 held high continuously, wr_window=1 → grants alternate w0, w1, w0, w1…, each a one-cycle pulse.
- disp_req every cycle while w0_req is high → w0_gnt stays 0. Drop disp_req → w0_gnt the next cycle.
- Clear started, wr_window dropped after 10 rows, reopened 5 cycles later → rows 10..27 cleared and clr_done after 28 clearing cycles in total.
- w1 writes row 30 → w1_gnt pulses and no row changes. disp fetch of row 30 returns 0 with disp_valid=1.

Source files
------------

// File: rtl/bitmap_pkg.sv
// Shared constants and types for the display bitmap arbiter.
// Default geometry of the 1-bit bitmap and the clear-sequencer states.
package bitmap_pkg;

    localparam int DEF_ROWS  = 28;
    localparam int DEF_COLS  = 80;
    localparam int DEF_ROW_W = 5;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The grant is combinational. A registered pointer remembers which requester won last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 means requester 1 won most recently, so requester 0 wins the next tie.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bitmap_access_arbiter.sv
// Owns the 1-bit display bitmap and shares it between scan-out, bulk clear and two writers.
// Scan-out always wins. Clear and masked writes proceed only inside the write window.
module bitmap_access_arbiter
    import bitmap_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_window,
    input  logic             disp_req,
    input  logic [ROW_W-1:0] disp_row,
    output logic [COLS-1:0]  disp_data,
    output logic             disp_valid,
    input  logic             w0_req,
    input  logic [ROW_W-1:0] w0_row,
    input  logic [COLS-1:0]  w0_data,
    input  logic [COLS-1:0]  w0_mask,
    output logic             w0_gnt,
    input  logic             w1_req,
    input  logic [ROW_W-1:0] w1_row,
    input  logic [COLS-1:0]  w1_data,
    input  logic [COLS-1:0]  w1_mask,
    output logic             w1_gnt,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [COLS-1:0]  mem_q [ROWS];
    clr_state_e       state_q;
    logic [ROW_W-1:0] cnt_q;
    logic             clr_done_q;
    logic [COLS-1:0]  disp_data_q;
    logic             disp_valid_q;
    logic [1:0]       gnt_q;

    logic             wr_ok;
    logic             clr_step;
    logic [1:0]       wr_elig;
    logic [1:0]       arb_gnt;
    logic [ROW_W-1:0] wr_row;
    logic [COLS-1:0]  wr_data;
    logic [COLS-1:0]  wr_mask;
    logic             wr_commit;

    // A writer whose grant is showing this cycle sits out, so a held request is not granted twice.
    always_comb begin
        wr_ok     = wr_window && !disp_req;
        clr_step  = (state_q == ST_CLEAR) && wr_ok && !clr_req;
        wr_elig   = {w1_req && !gnt_q[1], w0_req && !gnt_q[0]}
                    & {2{wr_ok && (state_q == ST_IDLE)}};
        wr_row    = arb_gnt[1] ? w1_row  : w0_row;
        wr_data   = arb_gnt[1] ? w1_data : w0_data;
        wr_mask   = arb_gnt[1] ? w1_mask : w0_mask;
        wr_commit = (arb_gnt != 2'b00) && (wr_row <= LAST_ROW);
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (wr_elig),
        .gnt_o (arb_gnt)
    );

    // Bitmap storage carries no reset; software clears it after power-up.
    always_ff @(posedge clk) begin
        if (clr_step) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_commit) begin
            mem_q[wr_row] <= (mem_q[wr_row] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            clr_done_q   <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            gnt_q        <= 2'b00;
        end else begin
            clr_done_q   <= 1'b0;
            gnt_q        <= arb_gnt;
            disp_valid_q <= disp_req;
            if (disp_req) begin
                disp_data_q <= (disp_row <= LAST_ROW) ? mem_q[disp_row] : '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_req) begin
                        cnt_q <= '0;
                    end else if (clr_step) begin
                        if (cnt_q == LAST_ROW) begin
                            state_q    <= ST_IDLE;
                            cnt_q      <= '0;
                            clr_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + ROW_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign w0_gnt     = gnt_q[0];
    assign w1_gnt     = gnt_q[1];
    assign clr_busy   = (state_q == ST_CLEAR);
    assign clr_done   = clr_done_q;

endmodule
